cv32e40x_event_log: RTL and testbench
=====================================

# cv32e40x_event_log

Parametrised successor to the core simulation logger. It captures up to NUM_CH per-cycle event channels (illegal instruction, ebreak, exception, …), keeps a saturating count per channel, and stores a timestamped record of each captured event in a circular buffer. Records drain through a valid/ready pop port. It sits beside cv32e40x_core, is fed from the writeback stage, and is read by testbench monitors or a debug trace port.

## Interface
- NUM_CH, 4: number of event channels; 1..16.
- DEPTH, 8: buffer entries; power of two, ≥2.
- CNT_WIDTH, 16: width of each per-channel counter and of the drop counter.
- OVERWRITE, 0: 1 = when full, overwrite the oldest record; 0 = drop the new record.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous clear of counters, buffer and drop count.
- mhartid_i  in  32  hart id; used only for display.
- evt_valid_i  in  NUM_CH  per-channel event strobe.
- evt_pc_i  in  NUM_CH×32  per-channel PC; unpacked array.
- rd_valid_o  out  1  oldest record is available.
- rd_ready_i  in  1  consumer accepts the record.
- rd_ch_o  out  $clog2(NUM_CH) (min 1)  channel index of the record.
- rd_pc_o  out  32  PC of the record.
- rd_time_o  out  32  cycle timestamp of the record.
- cnt_o  out  NUM_CH×CNT_WIDTH  per-channel event counts.
- drop_cnt_o  out  CNT_WIDTH  records not stored.
- level_o  out  $clog2(DEPTH+1)  current occupancy.
- full_o  out  1  level_o == DEPTH.

## Operation
- Free-running 32-bit cycle counter. Resets to 0, increments every cycle, wraps from 0xFFFF_FFFF to 0. clear_i does not affect it.
- Every asserted evt_valid_i[c] increments cnt_o[c] by 1. The counter saturates at all-ones.
- Per cycle, only the lowest-index asserted channel is the push candidate: {ch, pc, timestamp}.
- Each other channel asserted in the same cycle increments drop_cnt_o by 1. Total increment per cycle = popcount(evt_valid_i) − 1. drop_cnt_o saturates.
- A pop happens when rd_valid_o && rd_ready_i.
- Buffer full, no pop in that cycle:
  - OVERWRITE=1: the candidate replaces the oldest entry, the read pointer advances, and drop_cnt_o increments by 1.
  - OVERWRITE=0: the candidate is discarded and drop_cnt_o increments by 1.
- Buffer full, pop and push in the same cycle: both succeed in either mode. level_o is unchanged and no drop is counted.
- Buffer empty, push and rd_ready_i in the same cycle: no pop occurs, because rd_valid_o is still low.
- clear_i has priority over everything else in its cycle:
  - counters, drop count, pointers and level go to 0;
  - events presented in that cycle are neither counted nor stored.
- Pointers are log2(DEPTH) bits wide and wrap naturally. level_o is tracked separately.

## Timing
- Reset value of all outputs is 0. rd_valid_o=0, full_o=0, level_o=0.
- Push latency is 1 cycle: an event at edge N gives rd_valid_o=1 and the record fields after edge N.
- cnt_o, drop_cnt_o, level_o and full_o are registered and update one cycle after the causing event.
- The rd_* fields are driven combinationally from the buffer head. They are stable while rd_valid_o=1 and rd_ready_i=0, except under OVERWRITE=1 when full, where the head advances.
- When rst_i is asserted mid-operation, all state clears immediately and the timestamp restarts at 0.

## Configuration
- CV32E40X_EVENT_LOG_DISPLAY_EN defined:
  - at negedge clk_i, each stored record prints "%t: event ch %0d (core %0d) at PC 0x%h", using mhartid_i[3:0];
  - each dropped record prints a "dropped" warning line;
  - at time 0, all parameter values are displayed.
- Undefined: no $display code is present and the block is fully synthesizable.
- The display code is additionally excluded under FORMAL.

## Structure
- cv32e40x_pkg holds:
  - the typedef event_log_entry_t {ch, pc[31:0], time[31:0]};
  - the constant EVENT_LOG_MAX_CH = 16.
- One sub-module, cv32e40x_event_log_fifo, implements the circular buffer: push, pop, overwrite mode, level and full.
- The top level holds the arbiter, the counters, the timestamp and the display code.

## Test plan
- Reset, then a single event on ch2 with PC 0x0000_0100 at cycle 5 → next cycle: rd_valid_o=1, rd_ch_o=2, rd_pc_o=0x100, rd_time_o=5, cnt_o[2]=1.
- ch0, ch1 and ch3 fire together → ch0 stored; drop_cnt_o=2; each of cnt_o[0], cnt_o[1], cnt_o[3] = 1.
- DEPTH=8, OVERWRITE=0, rd_ready_i=0, 10 events → level_o=8, full_o=1, drop_cnt_o=2; the first pop returns event #1.
- Same stimulus with OVERWRITE=1 → drop_cnt_o=2; the first pop returns event #3.
- Full buffer, rd_ready_i=1 and a new event in the same cycle → level_o stays 8 and drop_cnt_o is unchanged.
- CNT_WIDTH=4, 20 events on ch1 → cnt_o[1]=15. clear_i with a same-cycle event → cnt_o[1]=0 and level_o=0.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// cv32e40x_pkg: shared record type and channel limit for the event logger
package cv32e40x_pkg;
  localparam int EVENT_LOG_MAX_CH = 16;
  typedef struct packed {
    logic [$clog2(EVENT_LOG_MAX_CH)-1:0] ch;
    logic [31:0]                         pc;
    logic [31:0]                         tstamp;
  } event_log_entry_t;
endpackage

// File: rtl/cv32e40x_event_log_fifo.sv
// cv32e40x_event_log_fifo: circular record buffer with drop-new or overwrite-oldest behaviour when full
module cv32e40x_event_log_fifo
  import cv32e40x_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter bit OVERWRITE = 1'b0,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  event_log_entry_t entry_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output event_log_entry_t head_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             drop_o
);
  event_log_entry_t mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic pop, store, ovw;
  assign full_o     = level_q == LW'(DEPTH);
  assign rd_valid_o = level_q != '0;
  assign pop        = rd_valid_o && rd_ready_i;
  assign store      = push_i && (!full_o || pop);
  assign drop_o     = push_i && full_o && !pop;
  // in overwrite mode the slot at wptr is the oldest record when full, so write and advance both pointers
  assign ovw        = drop_o && OVERWRITE;
  assign wptr_d     = wptr_q + PW'(store || ovw);
  assign rptr_d     = rptr_q + PW'(pop || ovw);
  assign level_d    = level_q + LW'(store) - LW'(pop);
  assign head_o     = mem_q[rptr_q];
  assign level_o    = level_q;
  // pointers, occupancy and storage; clear empties the buffer but keeps stale contents
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (store || ovw) mem_q[wptr_q] <= entry_i;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/cv32e40x_event_log.sv
// cv32e40x_event_log: per-channel saturating event counters plus timestamped record buffer; define CV32E40X_EVENT_LOG_DISPLAY_EN for console tracing
module cv32e40x_event_log
  import cv32e40x_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16,
  parameter bit OVERWRITE = 1'b0,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic [31:0]          mhartid_i,
  input  logic [NUM_CH-1:0]    evt_valid_i,
  input  logic [31:0]          evt_pc_i [NUM_CH],
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [CH_W-1:0]      rd_ch_o,
  output logic [31:0]          rd_pc_o,
  output logic [31:0]          rd_time_o,
  output logic [CNT_WIDTH-1:0] cnt_o [NUM_CH],
  output logic [CNT_WIDTH-1:0] drop_cnt_o,
  output logic [LW-1:0]        level_o,
  output logic                 full_o
);
  localparam int SW = CNT_WIDTH + 6;
  logic [31:0] ts_q;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [SW-1:0] drop_sum;
  logic [3:0] sel;
  logic [4:0] nevt, extra;
  logic any, fifo_drop;
  event_log_entry_t entry, head;
  logic unused_hartid;
  assign unused_hartid = ^mhartid_i;
  // lowest asserted channel wins the push slot; count all asserted channels
  always_comb begin
    sel  = '0;
    nevt = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      sel  = evt_valid_i[c] ? 4'(c) : sel;
      nevt = nevt + 5'(evt_valid_i[c]);
    end
  end
  assign any   = |evt_valid_i;
  assign extra = any ? nevt - 5'd1 : '0;
  assign entry = '{ch: sel, pc: evt_pc_i[sel], tstamp: ts_q};
  cv32e40x_event_log_fifo #(.DEPTH(DEPTH), .OVERWRITE(OVERWRITE)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear_i),
    .push_i    (any),
    .entry_i   (entry),
    .rd_ready_i(rd_ready_i),
    .rd_valid_o(rd_valid_o),
    .head_o    (head),
    .level_o   (level_o),
    .full_o    (full_o),
    .drop_o    (fifo_drop)
  );
  assign rd_ch_o   = CH_W'(head.ch);
  assign rd_pc_o   = head.pc;
  assign rd_time_o = head.tstamp;
  assign drop_sum  = SW'(drop_q) + SW'(extra) + SW'(fifo_drop);
  assign drop_d    = clear_i ? '0 : drop_sum > SW'({CNT_WIDTH{1'b1}}) ? '1 : drop_q + CNT_WIDTH'(extra) + CNT_WIDTH'(fifo_drop);
  // saturating per-channel next counts; clear wins over same-cycle events
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      cnt_d[c] = clear_i ? '0 : (evt_valid_i[c] && !(&cnt_q[c])) ? cnt_q[c] + 1'b1 : cnt_q[c];
  end
  // timestamp, counters and drop count; timestamp ignores clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_q   <= '0;
      drop_q <= '0;
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
    end else begin
      ts_q   <= ts_q + 32'd1;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
    end
  end
  assign cnt_o      = cnt_q;
  assign drop_cnt_o = drop_q;
`ifdef CV32E40X_EVENT_LOG_DISPLAY_EN
`ifndef FORMAL
  initial $display("cv32e40x_event_log: NUM_CH=%0d DEPTH=%0d CNT_WIDTH=%0d OVERWRITE=%0d", NUM_CH, DEPTH, CNT_WIDTH, OVERWRITE);
  // trace what the coming edge will store or drop
  always @(negedge clk_i) begin
    if (!rst_i && !clear_i && any) begin
      if (!fifo_drop || OVERWRITE)
        $display("%t: event ch %0d (core %0d) at PC 0x%h", $time, sel, mhartid_i[3:0], entry.pc);
      if (fifo_drop)
        $display("%t: warning: buffer full, record dropped (core %0d)", $time, mhartid_i[3:0]);
      for (int c = 0; c < NUM_CH; c++)
        if (evt_valid_i[c] && 4'(c) != sel)
          $display("%t: warning: event ch %0d (core %0d) at PC 0x%h dropped", $time, c, mhartid_i[3:0], evt_pc_i[c]);
    end
  end
`endif
`endif
endmodule

// File: tb/tb_cv32e40x_event_log.sv
// tb_cv32e40x_event_log: drop-new and overwrite/4-bit-counter instances against a queue-based reference model
module tb_cv32e40x_event_log;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, rdy = 1'b0;
  logic [3:0] evt = '0;
  logic [31:0] pc [4];
  logic [31:0] hart = 32'd3;
  logic rv [2];
  logic [1:0] rch [2];
  logic [31:0] rpc [2];
  logic [31:0] rt [2];
  logic [3:0] lvl [2];
  logic full [2];
  logic [15:0] cnt0 [4];
  logic [3:0] cnt1 [4];
  logic [15:0] drop0;
  logic [3:0] drop1;
  int ncmp = 0, nfail = 0;
  typedef struct {
    int ch;
    logic [31:0] pc;
    logic [31:0] t;
  } rec_t;
  rec_t q0[$], q1[$];
  int mcnt [2][4];
  int mdrop [2];
  int cmax [2] = '{65535, 15};
  logic [31:0] tmod;
  always #5 clk = ~clk;
  cv32e40x_event_log u0 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .mhartid_i(hart), .evt_valid_i(evt), .evt_pc_i(pc),
    .rd_valid_o(rv[0]), .rd_ready_i(rdy), .rd_ch_o(rch[0]), .rd_pc_o(rpc[0]), .rd_time_o(rt[0]),
    .cnt_o(cnt0), .drop_cnt_o(drop0), .level_o(lvl[0]), .full_o(full[0])
  );
  cv32e40x_event_log #(.CNT_WIDTH(4), .OVERWRITE(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .mhartid_i(hart), .evt_valid_i(evt), .evt_pc_i(pc),
    .rd_valid_o(rv[1]), .rd_ready_i(rdy), .rd_ch_o(rch[1]), .rd_pc_o(rpc[1]), .rd_time_o(rt[1]),
    .cnt_o(cnt1), .drop_cnt_o(drop1), .level_o(lvl[1]), .full_o(full[1])
  );
  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s inst%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask
  function automatic int qsize(input int k);
    return k == 0 ? q0.size() : q1.size();
  endfunction
  function automatic rec_t qfront(input int k);
    if (k == 0) return q0[0];
    return q1[0];
  endfunction
  task automatic qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask
  task automatic qpush(input int k, input rec_t r);
    if (k == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask
  function automatic int sat(input int k, input int v);
    return v > cmax[k] ? cmax[k] : v;
  endfunction
  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      mdrop[k] = 0;
      for (int c = 0; c < 4; c++) mcnt[k][c] = 0;
    end
    tmod = '0;
  endtask
  task automatic model_step();
    int n, lo;
    bit popd, isfull;
    rec_t r;
    if (clr) begin
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
        mdrop[k] = 0;
        for (int c = 0; c < 4; c++) mcnt[k][c] = 0;
      end
    end else begin
      n = 0;
      lo = -1;
      for (int c = 0; c < 4; c++) if (evt[c]) begin
        n++;
        if (lo < 0) lo = c;
      end
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < 4; c++) if (evt[c]) mcnt[k][c] = sat(k, mcnt[k][c] + 1);
        popd = rdy && qsize(k) > 0;
        isfull = qsize(k) == 8;
        if (popd) qpop(k);
        if (n > 0) begin
          mdrop[k] = sat(k, mdrop[k] + n - 1);
          r.ch = lo;
          r.pc = pc[lo];
          r.t = tmod;
          if (!isfull || popd) qpush(k, r);
          else begin
            if (k == 1) begin
              qpop(k);
              qpush(k, r);
            end
            mdrop[k] = sat(k, mdrop[k] + 1);
          end
        end
      end
    end
    tmod = tmod + 32'd1;
  endtask
  task automatic check_all();
    rec_t h;
    for (int k = 0; k < 2; k++) begin
      int sz = qsize(k);
      chk("rd_valid", k, 64'(rv[k]), 64'(sz > 0));
      chk("level", k, 64'(lvl[k]), 64'(sz));
      chk("full", k, 64'(full[k]), 64'(sz == 8));
      if (sz > 0) begin
        h = qfront(k);
        chk("rd_ch", k, 64'(rch[k]), 64'(h.ch));
        chk("rd_pc", k, 64'(rpc[k]), 64'(h.pc));
        chk("rd_time", k, 64'(rt[k]), 64'(h.t));
      end
      chk("drop_cnt", k, k ? 64'(drop1) : 64'(drop0), 64'(mdrop[k]));
      for (int c = 0; c < 4; c++)
        chk("cnt", k, k ? 64'(cnt1[c]) : 64'(cnt0[c]), 64'(mcnt[k][c]));
    end
  endtask
  task automatic cycle(input logic [3:0] e, input logic r, input logic c);
    evt = e;
    rdy = r;
    clr = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask
  initial begin
    for (int c = 0; c < 4; c++) pc[c] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all();
    repeat (5) cycle(4'b0000, 1'b0, 1'b0);
    pc[2] = 32'h0000_0100;
    cycle(4'b0100, 1'b0, 1'b0);
    chk("first_time", 0, 64'(rt[0]), 64'd5);
    chk("first_ch", 0, 64'(rch[0]), 64'd2);
    chk("first_pc", 0, 64'(rpc[0]), 64'h100);
    chk("first_cnt", 0, 64'(cnt0[2]), 64'd1);
    for (int c = 0; c < 4; c++) pc[c] = $urandom;
    cycle(4'b1011, 1'b0, 1'b0);
    chk("multi_drop", 0, 64'(drop0), 64'd2);
    cycle(4'b0010, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      pc[1] = 32'h1000 + 32'(i * 4);
      cycle(4'b0010, 1'b0, 1'b0);
    end
    chk("fill_level", 0, 64'(lvl[0]), 64'd8);
    chk("fill_full", 0, 64'(full[0]), 64'd1);
    chk("fill_drop", 0, 64'(drop0), 64'd2);
    chk("fill_drop", 1, 64'(drop1), 64'd2);
    chk("fill_head", 0, 64'(rpc[0]), 64'h1000);
    chk("fill_head", 1, 64'(rpc[1]), 64'h1008);
    pc[0] = 32'hABCD_0000;
    cycle(4'b0001, 1'b1, 1'b0);
    chk("full_pp_level", 0, 64'(lvl[0]), 64'd8);
    chk("full_pp_drop", 0, 64'(drop0), 64'd2);
    chk("full_pp_level", 1, 64'(lvl[1]), 64'd8);
    repeat (10) cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      pc[1] = $urandom;
      cycle(4'b0010, 1'($urandom_range(0, 1)), 1'b0);
    end
    chk("sat_cnt", 1, 64'(cnt1[1]), 64'd15);
    chk("sat_cnt", 0, 64'(cnt0[1]), 64'd20);
    cycle(4'b0010, 1'b0, 1'b1);
    chk("clear_cnt", 1, 64'(cnt1[1]), 64'd0);
    chk("clear_level", 0, 64'(lvl[0]), 64'd0);
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 4; c++) pc[c] = $urandom;
      cycle(4'($urandom & $urandom), i < 150 ? 1'($urandom_range(0, 4) == 0) : 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 80) == 0));
    end
    evt = '0;
    rdy = 1'b0;
    clr = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 0, 64'(rv[0]), 64'd0);
    chk("async_rst_level", 1, 64'(lvl[1]), 64'd0);
    chk("async_rst_drop", 0, 64'(drop0), 64'd0);
    chk("async_rst_pc", 0, 64'(rpc[0]), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all();
    repeat (3) cycle(4'b0000, 1'b0, 1'b0);
    pc[3] = 32'hDEAD_BEEC;
    cycle(4'b1000, 1'b0, 1'b0);
    chk("post_rst_time", 0, 64'(rt[0]), 64'd3);
    for (int i = 0; i < 100; i++) begin
      for (int c = 0; c < 4; c++) pc[c] = $urandom;
      cycle(4'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
